cnt_wrap_monitor: RTL and testbench

CNT_WRAP_MONITOR -- requirements
Module: cnt_wrap_monitor

---
 rtl/cnt_wrap_monitor.sv | 169 ++++++++++++++++
 tb/tb_cnt_wrap_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_wrap_monitor.sv
// Watches a 4-bit up/down counter: tallies wraps, flags illegal steps and
// queues wrap/error events in a small FIFO behind a valid/ready handshake.
module cnt_wrap_monitor #(
   parameter int FIFO_DEPTH = 4,
   parameter int WRAP_W     = 8
) (
   input  logic              cnt_clk,
   input  logic              cnt_rst,
   input  logic [3:0]        cnt_in,
   input  logic              mon_clr,
   input  logic              evt_rdy,
   output logic              evt_vld,
   output logic [1:0]        evt_type,
   output logic [2:0]        evt_seq,
   output logic [WRAP_W-1:0] up_wraps,
   output logic [WRAP_W-1:0] dn_wraps,
   output logic              dir_up,
   output logic              err_sticky,
   output logic              ovf_sticky
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;
   typedef enum logic [1:0] {
      EV_NONE = 2'b00,
      EV_UP   = 2'b01,
      EV_DN   = 2'b10,
      EV_ERR  = 2'b11
   } evt_kind_t;
   typedef struct packed {
      logic [1:0] kind;
      logic [2:0] seq;
   } evt_entry_t;

   state_t            r_state;
   logic [3:0]        r_prev;
   evt_entry_t        r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [2:0]        r_seq;
   logic [WRAP_W-1:0] r_up_wraps;
   logic [WRAP_W-1:0] r_dn_wraps;
   logic              r_dir_up;
   logic              r_err;
   logic              r_ovf;

   logic [3:0]  w_delta;
   logic        w_step_up;
   logic        w_step_dn;
   logic        w_step_err;
   logic        w_up_wrap;
   logic        w_dn_wrap;
   logic        w_track;
   logic        w_push_req;
   logic [1:0]  w_push_kind;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_push;
   logic        w_drop;
   evt_entry_t  w_head;

   // Step class comes from the modulo-16 delta; a wrap is always also a legal step.
   assign w_delta    = cnt_in - r_prev;
   assign w_step_up  = (w_delta == 4'd1);
   assign w_step_dn  = (w_delta == 4'hF);
   assign w_step_err = !(w_step_up || w_step_dn);
   assign w_up_wrap  = (r_prev == 4'hF) && (cnt_in == 4'h0);
   assign w_dn_wrap  = (r_prev == 4'h0) && (cnt_in == 4'hF);

   assign w_track     = (r_state == ST_TRACK);
   assign w_push_req  = w_track && (w_up_wrap || w_dn_wrap || w_step_err);
   assign w_push_kind = w_step_err ? EV_ERR : (w_up_wrap ? EV_UP : EV_DN);

   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && evt_rdy;
   assign w_push  = w_push_req && (!w_full || w_pop);
   assign w_drop  = w_push_req && !w_push;

   always_ff @(posedge cnt_clk or negedge cnt_rst) begin
      if (!cnt_rst) begin
         r_state    <= ST_INIT;
         r_prev     <= 4'h0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_seq      <= 3'd0;
         r_up_wraps <= '0;
         r_dn_wraps <= '0;
         r_dir_up   <= 1'b1;
         r_err      <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (mon_clr) begin
         r_state    <= ST_INIT;
         r_prev     <= 4'h0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_seq      <= 3'd0;
         r_up_wraps <= '0;
         r_dn_wraps <= '0;
         r_dir_up   <= 1'b1;
         r_err      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here so every branch sees pre-edge state.
         r_prev <= cnt_in;

         case (r_state)
            ST_INIT: r_state <= ST_TRACK;
            ST_TRACK: begin
               if (w_step_err) begin
                  r_state <= ST_FAULT;
                  r_err   <= 1'b1;
               end else begin
                  r_dir_up <= w_step_up;
               end
            end
            ST_FAULT: begin
               if (!w_step_err) begin
                  r_state  <= ST_TRACK;
                  r_dir_up <= w_step_up;
               end
            end
            default: r_state <= ST_INIT;
         endcase

         if (w_track && w_up_wrap && (r_up_wraps != '1))
            r_up_wraps <= r_up_wraps + WRAP_W'(1);
         if (w_track && w_dn_wrap && (r_dn_wraps != '1))
            r_dn_wraps <= r_dn_wraps + WRAP_W'(1);

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_seq    <= r_seq + 3'd1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_drop)
            r_ovf <= 1'b1;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; validity is carried by r_count and outputs are gated.
   always_ff @(posedge cnt_clk) begin
      if (w_push && !mon_clr)
         r_mem[r_wr_ptr] <= '{kind: w_push_kind, seq: r_seq};
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign evt_vld    = !w_empty;
   assign evt_type   = evt_vld ? w_head.kind : EV_NONE;
   assign evt_seq    = evt_vld ? w_head.seq : 3'd0;
   assign up_wraps   = r_up_wraps;
   assign dn_wraps   = r_dn_wraps;
   assign dir_up     = r_dir_up;
   assign err_sticky = r_err;
   assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_cnt_wrap_monitor.sv
// Directed bench for cnt_wrap_monitor: hand-computed vectors per feature,
// plus a WRAP_W=2 instance for tally saturation.
module tb_cnt_wrap_monitor;

   logic       cnt_clk = 1'b0;
   logic       cnt_rst;
   logic [3:0] cnt_in;
   logic       mon_clr;
   logic       evt_rdy;

   logic       evt_vld;
   logic [1:0] evt_type;
   logic [2:0] evt_seq;
   logic [7:0] up_wraps;
   logic [7:0] dn_wraps;
   logic       dir_up;
   logic       err_sticky;
   logic       ovf_sticky;

   logic       w2_vld;
   logic [1:0] w2_type;
   logic [2:0] w2_seq;
   logic [1:0] w2_up;
   logic [1:0] w2_dn;
   logic       w2_dir;
   logic       w2_err;
   logic       w2_ovf;

   int n_cmp = 0;
   int n_bad = 0;
   int hs_w2 = 0;

   always #5 cnt_clk = ~cnt_clk;

   cnt_wrap_monitor #(.FIFO_DEPTH(4), .WRAP_W(8)) dut (
      .cnt_clk(cnt_clk), .cnt_rst(cnt_rst), .cnt_in(cnt_in), .mon_clr(mon_clr),
      .evt_rdy(evt_rdy), .evt_vld(evt_vld), .evt_type(evt_type), .evt_seq(evt_seq),
      .up_wraps(up_wraps), .dn_wraps(dn_wraps), .dir_up(dir_up),
      .err_sticky(err_sticky), .ovf_sticky(ovf_sticky)
   );

   cnt_wrap_monitor #(.FIFO_DEPTH(4), .WRAP_W(2)) dut_w2 (
      .cnt_clk(cnt_clk), .cnt_rst(cnt_rst), .cnt_in(cnt_in), .mon_clr(mon_clr),
      .evt_rdy(evt_rdy), .evt_vld(w2_vld), .evt_type(w2_type), .evt_seq(w2_seq),
      .up_wraps(w2_up), .dn_wraps(w2_dn), .dir_up(w2_dir),
      .err_sticky(w2_err), .ovf_sticky(w2_ovf)
   );

   always @(posedge cnt_clk)
      if (w2_vld && evt_rdy) hs_w2 <= hs_w2 + 1;

   task automatic step(input logic [3:0] v);
      cnt_in = v;
      @(posedge cnt_clk);
      #1;
   endtask

   task automatic clear(input logic [3:0] v);
      mon_clr = 1'b1;
      step(v);
      mon_clr = 1'b0;
   endtask

   // Expects prev==E; leaves prev==0 after n up-wraps.
   task automatic run_up_wraps(input int n);
      logic [3:0] v;
      v = 4'hE;
      repeat (16 * (n - 1) + 2) begin
         v = v + 4'd1;
         step(v);
      end
   endtask

   task automatic test_reset;
      cnt_rst = 1'b0; cnt_in = 4'h0; mon_clr = 1'b0; evt_rdy = 1'b0;
      repeat (3) @(posedge cnt_clk);
      #1;
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL rst_vld: got %b want 0", evt_vld); end
      n_cmp++; if (evt_type !== 2'b00)  begin n_bad++; $display("FAIL rst_type: got %b want 00", evt_type); end
      n_cmp++; if (evt_seq !== 3'd0)    begin n_bad++; $display("FAIL rst_seq: got %0d want 0", evt_seq); end
      n_cmp++; if (up_wraps !== 8'd0)   begin n_bad++; $display("FAIL rst_up: got %0d want 0", up_wraps); end
      n_cmp++; if (dn_wraps !== 8'd0)   begin n_bad++; $display("FAIL rst_dn: got %0d want 0", dn_wraps); end
      n_cmp++; if (dir_up !== 1'b1)     begin n_bad++; $display("FAIL rst_dir: got %b want 1", dir_up); end
      n_cmp++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_sticky); end
      n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf_sticky); end
      @(negedge cnt_clk);
      cnt_rst = 1'b1;
   endtask

   task automatic test_up_wrap;
      evt_rdy = 1'b1;
      step(4'hE);
      step(4'hF);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL up_novld: got %b want 0", evt_vld); end
      step(4'h0);
      n_cmp++; if (evt_vld !== 1'b1)    begin n_bad++; $display("FAIL up_vld: got %b want 1", evt_vld); end
      n_cmp++; if (evt_type !== 2'b01)  begin n_bad++; $display("FAIL up_type: got %b want 01", evt_type); end
      n_cmp++; if (evt_seq !== 3'd0)    begin n_bad++; $display("FAIL up_seq: got %0d want 0", evt_seq); end
      n_cmp++; if (up_wraps !== 8'd1)   begin n_bad++; $display("FAIL up_tally: got %0d want 1", up_wraps); end
      step(4'h1);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL up_popped: got %b want 0", evt_vld); end
      n_cmp++; if (dir_up !== 1'b1)     begin n_bad++; $display("FAIL up_dir: got %b want 1", dir_up); end
   endtask

   task automatic test_down_wrap;
      evt_rdy = 1'b1;
      clear(4'h0);
      step(4'h1);
      step(4'h0);
      n_cmp++; if (dir_up !== 1'b0)     begin n_bad++; $display("FAIL dn_dir0: got %b want 0", dir_up); end
      step(4'hF);
      n_cmp++; if (evt_vld !== 1'b1)    begin n_bad++; $display("FAIL dn_vld: got %b want 1", evt_vld); end
      n_cmp++; if (evt_type !== 2'b10)  begin n_bad++; $display("FAIL dn_type: got %b want 10", evt_type); end
      n_cmp++; if (evt_seq !== 3'd0)    begin n_bad++; $display("FAIL dn_seq: got %0d want 0", evt_seq); end
      n_cmp++; if (dn_wraps !== 8'd1)   begin n_bad++; $display("FAIL dn_tally: got %0d want 1", dn_wraps); end
      n_cmp++; if (up_wraps !== 8'd0)   begin n_bad++; $display("FAIL dn_uptally: got %0d want 0", up_wraps); end
      step(4'hE);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL dn_popped: got %b want 0", evt_vld); end
      n_cmp++; if (dir_up !== 1'b0)     begin n_bad++; $display("FAIL dn_dir: got %b want 0", dir_up); end
   endtask

   task automatic test_error;
      evt_rdy = 1'b1;
      clear(4'h0);
      step(4'h2);
      step(4'h3);
      step(4'h9);
      n_cmp++; if (evt_vld !== 1'b1)    begin n_bad++; $display("FAIL err_vld: got %b want 1", evt_vld); end
      n_cmp++; if (evt_type !== 2'b11)  begin n_bad++; $display("FAIL err_type: got %b want 11", evt_type); end
      n_cmp++; if (evt_seq !== 3'd0)    begin n_bad++; $display("FAIL err_seq: got %0d want 0", evt_seq); end
      n_cmp++; if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_sticky); end
      step(4'hA);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL err_ret_vld: got %b want 0", evt_vld); end
      n_cmp++; if (up_wraps !== 8'd0 || dn_wraps !== 8'd0)
         begin n_bad++; $display("FAIL err_tally: got %0d/%0d want 0/0", up_wraps, dn_wraps); end
      step(4'hC);
      n_cmp++; if (evt_vld !== 1'b1 || evt_type !== 2'b11 || evt_seq !== 3'd1)
         begin n_bad++; $display("FAIL err_track2: got vld=%b type=%b seq=%0d want 1/11/1", evt_vld, evt_type, evt_seq); end
      step(4'hF);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL fault_noevt: got %b want 0", evt_vld); end
      step(4'h0);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL fault_wrap_evt: got %b want 0", evt_vld); end
      n_cmp++; if (up_wraps !== 8'd0)   begin n_bad++; $display("FAIL fault_wrap_tally: got %0d want 0", up_wraps); end
      n_cmp++; if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b want 1", err_sticky); end
      step(4'hF);
      n_cmp++; if (evt_vld !== 1'b1 || evt_type !== 2'b10 || evt_seq !== 3'd2)
         begin n_bad++; $display("FAIL fault_exit: got vld=%b type=%b seq=%0d want 1/10/2", evt_vld, evt_type, evt_seq); end
      n_cmp++; if (dn_wraps !== 8'd1 || dir_up !== 1'b0)
         begin n_bad++; $display("FAIL fault_exit_dn: got dn=%0d dir=%b want 1/0", dn_wraps, dir_up); end
   endtask

   task automatic test_overflow;
      clear(4'h0);
      evt_rdy = 1'b0;
      step(4'hE);
      run_up_wraps(5);
      n_cmp++; if (evt_vld !== 1'b1 || evt_type !== 2'b01 || evt_seq !== 3'd0)
         begin n_bad++; $display("FAIL ovf_head: got vld=%b type=%b seq=%0d want 1/01/0", evt_vld, evt_type, evt_seq); end
      n_cmp++; if (up_wraps !== 8'd5)   begin n_bad++; $display("FAIL ovf_tally: got %0d want 5", up_wraps); end
      n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_sticky); end
      evt_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (evt_vld !== 1'b1 || evt_seq !== 3'(k))
            begin n_bad++; $display("FAIL ovf_drain%0d: got vld=%b seq=%0d want 1/%0d", k, evt_vld, evt_seq, k); end
         step(4'(k + 1));
      end
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL ovf_empty: got %b want 0", evt_vld); end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_type [4];
      exp_type = '{2'b10, 2'b01, 2'b10, 2'b01};
      clear(4'h0);
      evt_rdy = 1'b0;
      step(4'hE);
      step(4'hF);
      step(4'h0);
      step(4'hF);
      step(4'h0);
      step(4'hF);
      n_cmp++; if (evt_vld !== 1'b1 || evt_type !== 2'b01 || evt_seq !== 3'd0)
         begin n_bad++; $display("FAIL b2b_full: got vld=%b type=%b seq=%0d want 1/01/0", evt_vld, evt_type, evt_seq); end
      evt_rdy = 1'b1;
      step(4'h0);
      n_cmp++; if (evt_seq !== 3'd1 || evt_type !== 2'b10)
         begin n_bad++; $display("FAIL b2b_pushpop: got type=%b seq=%0d want 10/1", evt_type, evt_seq); end
      n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL b2b_noovf: got %b want 0", ovf_sticky); end
      evt_rdy = 1'b0;
      step(4'hF);
      n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL b2b_ovf: got %b want 1", ovf_sticky); end
      n_cmp++; if (up_wraps !== 8'd3 || dn_wraps !== 8'd3)
         begin n_bad++; $display("FAIL b2b_tally: got %0d/%0d want 3/3", up_wraps, dn_wraps); end
      evt_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (evt_vld !== 1'b1 || evt_seq !== 3'(k + 1) || evt_type !== exp_type[k])
            begin n_bad++; $display("FAIL b2b_drain%0d: got vld=%b type=%b seq=%0d want 1/%b/%0d", k, evt_vld, evt_type, evt_seq, exp_type[k], k + 1); end
         step(4'(14 - k));
      end
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL b2b_empty: got %b want 0", evt_vld); end
   endtask

   task automatic test_saturation;
      int base;
      clear(4'h0);
      evt_rdy = 1'b1;
      step(4'hE);
      base = hs_w2;
      run_up_wraps(5);
      step(4'h1);
      n_cmp++; if (w2_up !== 2'd3)      begin n_bad++; $display("FAIL sat_tally: got %0d want 3", w2_up); end
      n_cmp++; if (hs_w2 - base !== 5)  begin n_bad++; $display("FAIL sat_events: got %0d want 5", hs_w2 - base); end
      n_cmp++; if (up_wraps !== 8'd5)   begin n_bad++; $display("FAIL sat_wide: got %0d want 5", up_wraps); end
   endtask

   task automatic test_clear;
      clear(4'h0);
      evt_rdy = 1'b0;
      step(4'hE);
      step(4'hF);
      step(4'h0);
      step(4'h5);
      step(4'h4);
      n_cmp++; if (evt_vld !== 1'b1 || err_sticky !== 1'b1 || dir_up !== 1'b0)
         begin n_bad++; $display("FAIL clr_pre: got vld=%b err=%b dir=%b want 1/1/0", evt_vld, err_sticky, dir_up); end
      clear(4'h6);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL clr_vld: got %b want 0", evt_vld); end
      n_cmp++; if (up_wraps !== 8'd0 || dn_wraps !== 8'd0)
         begin n_bad++; $display("FAIL clr_tally: got %0d/%0d want 0/0", up_wraps, dn_wraps); end
      n_cmp++; if (err_sticky !== 1'b0 || ovf_sticky !== 1'b0)
         begin n_bad++; $display("FAIL clr_sticky: got %b/%b want 0/0", err_sticky, ovf_sticky); end
      n_cmp++; if (dir_up !== 1'b1)     begin n_bad++; $display("FAIL clr_dir: got %b want 1", dir_up); end
      step(4'h7);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL clr_init: got %b want 0", evt_vld); end
      step(4'h5);
      n_cmp++; if (evt_vld !== 1'b1 || evt_type !== 2'b11 || evt_seq !== 3'd0)
         begin n_bad++; $display("FAIL clr_seq: got vld=%b type=%b seq=%0d want 1/11/0", evt_vld, evt_type, evt_seq); end
   endtask

   task automatic test_reset_mid;
      evt_rdy = 1'b0;
      step(4'h6);
      #2;
      cnt_rst = 1'b0;
      #1;
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL arst_vld: got %b want 0", evt_vld); end
      n_cmp++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", err_sticky); end
      @(negedge cnt_clk);
      cnt_rst = 1'b1;
      step(4'h9);
      n_cmp++; if (evt_vld !== 1'b0)    begin n_bad++; $display("FAIL arst_init: got %b want 0", evt_vld); end
      step(4'h3);
      n_cmp++; if (evt_vld !== 1'b1 || evt_type !== 2'b11 || evt_seq !== 3'd0)
         begin n_bad++; $display("FAIL arst_track: got vld=%b type=%b seq=%0d want 1/11/0", evt_vld, evt_type, evt_seq); end
   endtask

   initial begin
      test_reset;
      test_up_wrap;
      test_down_wrap;
      test_error;
      test_overflow;
      test_back_to_back;
      test_saturation;
      test_clear;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
